// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared RV32I pipeline types: decoded control bundle, bubble encoding and datapath sizes.
package pipeline_pkg;

  localparam int XLEN      = 32;
  localparam int CTRL_W    = 16;
  localparam int MEMRD_BIT = 0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  // mem_read sits in bit 0 so it lines up with MEMRD_BIT
  typedef struct packed {
    alu_op_e     alu_op;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic [1:0]  wb_sel;
    logic        mem_write;
    logic        reg_wren;
    logic        pc_rel;
    logic        mem_read;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

  function automatic logic reads_reg(input logic used, input logic [4:0] src,
                                     input logic [4:0] dst);
    return used & (src == dst);
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-stage instruction bundle as offered to the ID/EX boundary.
interface id_ex_pipe_reg_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic              rs1_used;
  logic              rs2_used;
  logic [4:0]        rd_addr;
  logic [XLEN-1:0]   imm;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid, pc, rs1_data, rs2_data, rs1_addr, rs2_addr,
           rs1_used, rs2_used, rd_addr, imm, ctrl
  );

  modport slave (
    input  valid, pc, rs1_data, rs2_data, rs1_addr, rs2_addr,
           rs1_used, rs2_used, rd_addr, imm, ctrl
  );
endinterface

// File: rtl/id_ex_pipe_reg_hazard.sv
// Load-use detector: a load in EX whose rd is read by the real instruction in ID.
module id_hazard_detect
  import pipeline_pkg::*;
(
  id_ex_pipe_reg_if.slave id_bus,
  input  logic            ex_valid_i,
  input  logic            ex_mem_read_i,
  input  logic [4:0]      ex_rd_i,
  output logic            lu_o
);

  logic ex_is_load;
  logic id_depends;

  always_comb begin
    ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0);
    id_depends = reads_reg(id_bus.rs1_used, id_bus.rs1_addr, ex_rd_i) |
                 reads_reg(id_bus.rs2_used, id_bus.rs2_addr, ex_rd_i);
    lu_o       = ex_is_load & id_bus.valid & id_depends;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with load-use bubble insertion, flush squash and global hold.
module id_ex_pipe_reg
  import pipeline_pkg::*;
#(
  parameter int CTRL_W    = pipeline_pkg::CTRL_W,
  parameter int MEMRD_BIT = pipeline_pkg::MEMRD_BIT,
  parameter int XLEN      = pipeline_pkg::XLEN
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid_id,
  input  logic [XLEN-1:0]   i_pc_id,
  input  logic [XLEN-1:0]   i_rs1_data_id,
  input  logic [XLEN-1:0]   i_rs2_data_id,
  input  logic [4:0]        i_rs1_addr_id,
  input  logic [4:0]        i_rs2_addr_id,
  input  logic              i_rs1_used_id,
  input  logic              i_rs2_used_id,
  input  logic [4:0]        i_rd_addr_id,
  input  logic [XLEN-1:0]   i_imm_id,
  input  logic [CTRL_W-1:0] i_ctrl_id,
  input  logic              i_flush,
  input  logic              i_hold,
  output logic              o_stall_id,
  output logic              o_valid_ex,
  output logic [XLEN-1:0]   o_pc_ex,
  output logic [XLEN-1:0]   o_rs1_data_ex,
  output logic [XLEN-1:0]   o_rs2_data_ex,
  output logic [XLEN-1:0]   o_imm_ex,
  output logic [4:0]        o_rs1_addr_ex,
  output logic [4:0]        o_rs2_addr_ex,
  output logic [4:0]        o_rd_addr_ex,
  output logic [CTRL_W-1:0] o_ctrl_ex
);

  id_ex_pipe_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) id_bus ();

  assign id_bus.valid    = i_valid_id;
  assign id_bus.pc       = i_pc_id;
  assign id_bus.rs1_data = i_rs1_data_id;
  assign id_bus.rs2_data = i_rs2_data_id;
  assign id_bus.rs1_addr = i_rs1_addr_id;
  assign id_bus.rs2_addr = i_rs2_addr_id;
  assign id_bus.rs1_used = i_rs1_used_id;
  assign id_bus.rs2_used = i_rs2_used_id;
  assign id_bus.rd_addr  = i_rd_addr_id;
  assign id_bus.imm      = i_imm_id;
  assign id_bus.ctrl     = i_ctrl_id;

  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q,  rd_addr_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic              lu;

  id_hazard_detect u_hazard (
    .id_bus        (id_bus),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[MEMRD_BIT]),
    .ex_rd_i       (rd_addr_q),
    .lu_o          (lu)
  );

  assign o_stall_id = (lu | i_hold) & ~i_flush;

  // Flush beats hold beats load-use; a bubble is the all-zero register image
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    ctrl_d     = ctrl_q;
    if (i_flush || (!i_hold && lu)) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rd_addr_d  = '0;
      ctrl_d     = '0;
    end else if (!i_hold) begin
      valid_d    = id_bus.valid;
      pc_d       = id_bus.pc;
      rs1_data_d = id_bus.rs1_data;
      rs2_data_d = id_bus.rs2_data;
      imm_d      = id_bus.imm;
      rs1_addr_d = id_bus.rs1_addr;
      rs2_addr_d = id_bus.rs2_addr;
      rd_addr_d  = id_bus.valid ? id_bus.rd_addr : 5'd0;
      ctrl_d     = id_bus.valid ? id_bus.ctrl : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign o_valid_ex    = valid_q;
  assign o_pc_ex       = pc_q;
  assign o_rs1_data_ex = rs1_data_q;
  assign o_rs2_data_ex = rs2_data_q;
  assign o_imm_ex      = imm_q;
  assign o_rs1_addr_ex = rs1_addr_q;
  assign o_rs2_addr_ex = rs2_addr_q;
  assign o_rd_addr_ex  = rd_addr_q;
  assign o_ctrl_ex     = ctrl_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed hazard scenarios plus random traffic.
module tb_id_ex_pipe_reg;

  typedef struct {
    bit        valid;
    bit [31:0] pc, d1, d2, imm;
    bit [4:0]  a1, a2, rd;
    bit        u1, u2;
    bit [15:0] ctrl;
    bit        flush, hold;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  a1, a2, rd;
    logic [15:0] ctrl;
  } ex_t;

  typedef struct {
    bit  stall;
    ex_t ex;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic hold = 1'b0;

  logic        stall;
  logic        v_ex;
  logic [31:0] pc_ex, d1_ex, d2_ex, imm_ex;
  logic [4:0]  a1_ex, a2_ex, rd_ex;
  logic [15:0] ctrl_ex;
  ex_t         dut_ex;

  id_ex_pipe_reg_if #(.XLEN(32), .CTRL_W(16)) id_bus ();

  id_ex_pipe_reg #(.CTRL_W(16), .MEMRD_BIT(0), .XLEN(32)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_valid_id    (id_bus.valid),
    .i_pc_id       (id_bus.pc),
    .i_rs1_data_id (id_bus.rs1_data),
    .i_rs2_data_id (id_bus.rs2_data),
    .i_rs1_addr_id (id_bus.rs1_addr),
    .i_rs2_addr_id (id_bus.rs2_addr),
    .i_rs1_used_id (id_bus.rs1_used),
    .i_rs2_used_id (id_bus.rs2_used),
    .i_rd_addr_id  (id_bus.rd_addr),
    .i_imm_id      (id_bus.imm),
    .i_ctrl_id     (id_bus.ctrl),
    .i_flush       (flush),
    .i_hold        (hold),
    .o_stall_id    (stall),
    .o_valid_ex    (v_ex),
    .o_pc_ex       (pc_ex),
    .o_rs1_data_ex (d1_ex),
    .o_rs2_data_ex (d2_ex),
    .o_imm_ex      (imm_ex),
    .o_rs1_addr_ex (a1_ex),
    .o_rs2_addr_ex (a2_ex),
    .o_rd_addr_ex  (rd_ex),
    .o_ctrl_ex     (ctrl_ex)
  );

  always #5 clk = ~clk;

  always_comb dut_ex = {v_ex, pc_ex, d1_ex, d2_ex, imm_ex, a1_ex, a2_ex, rd_ex, ctrl_ex};

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  ex_t  model = '0;
  bit   drop_pending = 0;
  bit   have_pend = 0;
  bit   last_stall = 0;

  // Reference: what EX should hold after the edge, from the pipeline rules
  function automatic bit load_use(ex_t cur, stim_t s);
    bit ex_load_writes = cur.valid && cur.ctrl[0] && (cur.rd != 5'd0);
    bit id_reads_it    = (s.u1 && s.a1 == cur.rd) || (s.u2 && s.a2 == cur.rd);
    return ex_load_writes && s.valid && id_reads_it;
  endfunction

  function automatic ex_t next_ex(ex_t cur, stim_t s);
    ex_t n = '0;
    if (s.flush) return n;
    if (s.hold) return cur;
    if (load_use(cur, s)) return n;
    n.valid = s.valid;
    n.pc = s.pc; n.d1 = s.d1; n.d2 = s.d2; n.imm = s.imm;
    n.a1 = s.a1; n.a2 = s.a2;
    n.rd   = s.valid ? s.rd : 5'd0;
    n.ctrl = s.valid ? s.ctrl : 16'h0;
    return n;
  endfunction

  task automatic apply(input stim_t s);
    id_bus.valid    = s.valid;
    id_bus.pc       = s.pc;
    id_bus.rs1_data = s.d1;
    id_bus.rs2_data = s.d2;
    id_bus.rs1_addr = s.a1;
    id_bus.rs2_addr = s.a2;
    id_bus.rs1_used = s.u1;
    id_bus.rs2_used = s.u2;
    id_bus.rd_addr  = s.rd;
    id_bus.imm      = s.imm;
    id_bus.ctrl     = s.ctrl;
    flush           = s.flush;
    hold            = s.hold;
  endtask

  task automatic issue(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    e.stall = (load_use(model, s) || s.hold) && !s.flush;
    e.ex    = next_ex(model, s);
    sbq.push_back(e);
    model      = e.ex;
    last_stall = e.stall;
  endtask

  function automatic stim_t instr(bit [31:0] pc, bit [4:0] rd, bit [4:0] a1, bit u1,
                                  bit [4:0] a2, bit u2, bit load);
    stim_t s;
    s.valid = 1; s.pc = pc; s.rd = rd;
    s.a1 = a1; s.u1 = u1; s.a2 = a2; s.u2 = u2;
    s.d1 = 32'h1000 + pc; s.d2 = 32'h2000 + pc; s.imm = 32'hFFFF_FFF0 + pc;
    s.ctrl = load ? 16'h0005 : 16'h0004;
    s.flush = 0; s.hold = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom_range(0, 5) != 0);
    s.pc  = $urandom; s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
    s.a1  = 5'($urandom_range(0, 3)); s.a2 = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 3));
    s.u1  = 1'($urandom); s.u2 = 1'($urandom);
    s.ctrl  = 16'($urandom);
    s.flush = ($urandom_range(0, 9) == 0);
    s.hold  = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  task automatic check_zero(input string name);
    checks++;
    if (dut_ex !== '0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ex=%h stall=%b, expected ex=0 stall=0", name, dut_ex, stall);
    end
  endtask

  // Monitor: compare the stall for the current cycle, then EX contents one edge later
  initial begin
    exp_t e;
    ex_t  pend;
    forever begin
      @(negedge clk);
      if (drop_pending) begin
        have_pend    = 0;
        drop_pending = 0;
      end
      if (have_pend) begin
        checks++;
        if (dut_ex !== pend) begin
          errors++;
          $display("FAIL ex_regs: got %h expected %h", dut_ex, pend);
        end
        have_pend = 0;
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (stall !== e.stall) begin
          errors++;
          $display("FAIL stall_id: got %b expected %b", stall, e.stall);
        end
        pend      = e.ex;
        have_pend = 1;
      end
    end
  end

  initial begin
    stim_t s, prev;
    stim_t idle;
    idle = '{default: 0};
    apply(idle);
    #12;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // pass-through: add x3,x1,x2
    s = instr(32'h10, 5'd3, 5'd1, 1, 5'd2, 1, 0);
    s.d1 = 32'd5; s.d2 = 32'd7;
    issue(s);
    issue(idle);

    // load-use: lw x5 then add x6,x5,x1 -> one bubble, then the add
    issue(instr(32'h20, 5'd5, 5'd1, 1, 5'd0, 0, 1));
    s = instr(32'h24, 5'd6, 5'd5, 1, 5'd1, 1, 0);
    issue(s);
    issue(s);
    // back-to-back dependent loads
    issue(instr(32'h28, 5'd7, 5'd6, 1, 5'd0, 0, 1));
    s = instr(32'h2C, 5'd8, 5'd7, 1, 5'd0, 0, 1);
    issue(s);
    issue(s);
    s = instr(32'h30, 5'd9, 5'd1, 1, 5'd8, 1, 0);
    issue(s);
    issue(s);

    // no false stall: lw x0 vs rs1=0; lw x5 vs rs2=5 unused
    issue(instr(32'h40, 5'd0, 5'd1, 1, 5'd0, 0, 1));
    issue(instr(32'h44, 5'd2, 5'd0, 1, 5'd0, 1, 0));
    issue(instr(32'h48, 5'd5, 5'd1, 1, 5'd0, 0, 1));
    issue(instr(32'h4C, 5'd2, 5'd1, 1, 5'd5, 0, 0));

    // flush together with a load-use, then a 3-cycle hold
    issue(instr(32'h50, 5'd5, 5'd1, 1, 5'd0, 0, 1));
    s = instr(32'h54, 5'd6, 5'd5, 1, 5'd0, 0, 0);
    s.flush = 1;
    issue(s);
    issue(instr(32'h58, 5'd4, 5'd1, 1, 5'd2, 1, 0));
    s = instr(32'h5C, 5'd3, 5'd1, 1, 5'd2, 1, 0);
    s.hold = 1;
    repeat (3) issue(s);
    s.hold = 0;
    issue(s);

    // reset in the middle of a load-use stall
    issue(instr(32'h60, 5'd5, 5'd1, 1, 5'd0, 0, 1));
    issue(instr(32'h64, 5'd6, 5'd5, 1, 5'd0, 0, 0));
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_before_reset: got %b expected 1", stall);
    end
    drop_pending = 1;
    rst_n = 1'b0;
    apply(idle);
    model = '0;
    #1;
    check_zero("reset_mid_stall");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic; a stalled ID instruction is re-presented unchanged
    prev = idle;
    for (int i = 0; i < 500; i++) begin
      if (last_stall) begin
        s = prev;
        s.flush = ($urandom_range(0, 9) == 0);
        s.hold  = ($urandom_range(0, 5) == 0);
      end else begin
        s = rand_stim();
      end
      issue(s);
      prev = s;
    end
    issue(idle);

    for (int n = 0; n < 20 && (sbq.size() != 0 || have_pend); n++) @(negedge clk);
    @(posedge clk);
    if (sbq.size() != 0 || have_pend) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
